// File: rtl/bch31163_lfsr_encoder.sv
// ---------------------------------------------------------------------------
// bch31163_lfsr_encoder
//
// Bit-serial systematic BCH(31,16,3) encoder. Each accepted 16-bit message
// is clocked MSB first through a 15-stage LFSR that divides by
// g(x) = x^15+x^11+x^10+x^9+x^8+x^7+x^5+x^3+x^2+x+1 (GEN_POLY = 16'h8FAF).
// The codeword is presented as {message[15:0], parity[14:0]}, which is the
// codeword_in format expected by bch31163_decoder.
//
// Handshake: valid/ready on both sides. All outputs are registered, so
// in_valid never reaches in_ready and out_ready never reaches out_valid
// through combinational logic. A word occupies the block for at least 18
// cycles: 1 accept edge, 16 shift edges, 1 output handshake edge. After that
// the block spends one IDLE cycle re-arming in_ready.
//
// Optional build macro BCH31163_ERR_INJECT_EN:
//   adds input err_mask[30:0] (sampled with data_in on the accept edge) and
//   output inject_active. The emitted codeword is the clean codeword XOR the
//   sampled mask, so decoder benches can inject errors in-line.
// ---------------------------------------------------------------------------
module bch31163_lfsr_encoder #(
  parameter logic [15:0] GEN_POLY = 16'h8FAF,
  parameter int          DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [30:0]       codeword_out,
`ifdef BCH31163_ERR_INJECT_EN
  input  logic [30:0]       err_mask,
  output logic              inject_active,
`endif
  output logic              busy
);

  // -------------------------------------------------------------------------
  // Configuration sanity checks (elaboration time only)
  // -------------------------------------------------------------------------
  generate
    if (DATA_W != 16) begin : g_bad_data_w
      $error("bch31163_lfsr_encoder: DATA_W must be 16 for BCH(31,16)");
    end
    if (GEN_POLY[15] != 1'b1) begin : g_bad_poly
      $error("bch31163_lfsr_encoder: GEN_POLY bit 15 must be set (degree-15 generator)");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_reg;
  logic [14:0]         lfsr_reg;
  logic [3:0]          cnt_reg;
  logic [DATA_W-1:0]   msg_reg;
  logic [30:0]         cw_reg;
  logic                out_valid_reg;
  logic                in_ready_reg;
  logic                busy_reg;

  // Mask applied to the clean codeword on the SHIFT->HOLD edge. It is all
  // zero in the default build so that the datapath is identical either way.
  logic [30:0]         cw_mask;

`ifdef BCH31163_ERR_INJECT_EN
  logic [30:0]         mask_reg;
  logic                inject_reg;

  assign cw_mask       = mask_reg;
  assign inject_active = inject_reg;
`else
  assign cw_mask       = 31'd0;
`endif

  // -------------------------------------------------------------------------
  // LFSR next-state
  //
  // The message bit for this shift is selected by the counter (MSB first),
  // leaving msg_reg intact so it can be reused as the systematic part of the
  // codeword. Bit 15 of GEN_POLY is the implicit x^15 term and is represented
  // by lfsr_reg[14] falling off the top of the register.
  // -------------------------------------------------------------------------
  logic        msg_bit;
  logic        fb;
  logic [14:0] lfsr_next;

  assign msg_bit = msg_reg[4'd15 - cnt_reg];
  assign fb      = msg_bit ^ lfsr_reg[14];

  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_lfsr_tap
      if (gi == 0) begin : g_tap_lsb
        assign lfsr_next[gi] = fb & GEN_POLY[gi];
      end else begin : g_tap_upper
        assign lfsr_next[gi] = lfsr_reg[gi-1] ^ (fb & GEN_POLY[gi]);
      end
    end
  endgenerate

  // Clean codeword as it will exist after the final shift edge.
  logic [30:0] cw_next;
  assign cw_next = {msg_reg, lfsr_next};

  // -------------------------------------------------------------------------
  // Control FSM and all registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      lfsr_reg      <= 15'd0;
      cnt_reg       <= 4'd0;
      msg_reg       <= '0;
      cw_reg        <= 31'd0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef BCH31163_ERR_INJECT_EN
      mask_reg      <= 31'd0;
      inject_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          out_valid_reg <= 1'b0;
          if (in_valid && in_ready_reg) begin
            // Accept edge: capture the word and start a fresh division.
            msg_reg      <= data_in;
            lfsr_reg     <= 15'd0;
            cnt_reg      <= 4'd0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= SHIFT;
`ifdef BCH31163_ERR_INJECT_EN
            mask_reg     <= err_mask;
`endif
          end else begin
            // in_ready rises one cycle after entering IDLE (also after reset).
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
          end
        end

        SHIFT: begin
          lfsr_reg <= lfsr_next;
          cnt_reg  <= cnt_reg + 4'd1;
          if (cnt_reg == 4'd15) begin
            // Last message bit: lfsr_next now holds the parity remainder.
            cw_reg        <= cw_next ^ cw_mask;
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
`ifdef BCH31163_ERR_INJECT_EN
            inject_reg    <= |mask_reg;
`endif
          end
        end

        HOLD: begin
          // codeword_out deliberately keeps its value after the handshake.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
`ifdef BCH31163_ERR_INJECT_EN
            inject_reg    <= 1'b0;
`endif
          end
        end

        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_reg;
  assign out_valid    = out_valid_reg;
  assign codeword_out = cw_reg;
  assign busy         = busy_reg;

  // -------------------------------------------------------------------------
  // Protocol invariants
  // -------------------------------------------------------------------------
  // Input and output sides never overlap.
  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready_reg && out_valid_reg));

  // While stalled in HOLD the presented codeword must not move.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_reg && !out_ready) |=> (out_valid_reg && $stable(cw_reg)));

  // busy covers exactly the SHIFT and HOLD states.
  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
    busy_reg == (state_reg != IDLE));

endmodule

// File: tb/tb_bch31163_lfsr_encoder.sv
// ---------------------------------------------------------------------------
// tb_bch31163_lfsr_encoder
//
// Scoreboard bench: the driver pushes the expected codeword on every accept
// edge, an independent monitor pops and compares on every output handshake.
// Directed vectors use hand-computed codewords; a short random run uses a
// long-division reference model. Define BCH31163_ERR_INJECT_EN to also
// exercise the error-injection ports.
// ---------------------------------------------------------------------------
module tb_bch31163_lfsr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] codeword_out;
  logic        busy;
`ifdef BCH31163_ERR_INJECT_EN
  logic [30:0] err_mask;
  logic        inject_active;
`endif

  bch31163_lfsr_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .codeword_out (codeword_out),
`ifdef BCH31163_ERR_INJECT_EN
    .err_mask     (err_mask),
    .inject_active(inject_active),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  int pushed = 0;
  int popped = 0;
  int acc_cycle = 0;
  int ready_mode = 1;   // 0: out_ready low, 1: high, 2: random

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    logic [30:0] cw;
    logic [15:0] data;
    logic        inj;
  } exp_t;

  exp_t sb_q[$];

  // Remainder of c(x) / g(x) by plain polynomial long division.
  function automatic logic [14:0] poly_mod(input logic [30:0] c);
    logic [30:0] r;
    r = c;
    for (int i = 30; i >= 15; i--) begin
      if (r[i]) r = r ^ (31'h0000_8FAF << (i - 15));
    end
    return r[14:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Only driver of out_ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: a handshake seen here completes on the next rising edge.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h, expected no output (t=%0t)", codeword_out, $time);
        end else begin
          e = sb_q.pop_front();
          popped++;
          $display("out  #%0d data=%h codeword=%h expected=%h", popped, e.data, codeword_out, e.cw);
          check("codeword", 32'(codeword_out), 32'(e.cw));
          check("message_field", 32'(codeword_out[30:15]), 32'(e.data));
          if (!e.inj) check("remainder_zero", 32'(poly_mod(codeword_out)), 32'd0);
`ifdef BCH31163_ERR_INJECT_EN
          check("inject_active", 32'(inject_active), 32'(e.inj));
`endif
        end
      end
    end
  end

  // Offer one word; on acceptance optionally push its expected codeword.
  task automatic send_word(input logic [15:0] d, input logic [30:0] mask,
                           input logic [30:0] exp_cw, input bit push, input int idle);
    bit   accepted;
    exp_t e;
    accepted = 1'b0;
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    data_in  = d;
`ifdef BCH31163_ERR_INJECT_EN
    err_mask = mask;
`endif
    for (int n = 0; n < 300 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    data_in  = 16'($urandom);
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept, expected accept of %h", d);
    end else begin
      acc_cycle = cycle_cnt;
      $display("in   data=%h mask=%h expected=%h", d, mask, exp_cw);
      if (push) begin
        e.cw   = exp_cw;
        e.data = d;
        e.inj  = |mask;
        sb_q.push_back(e);
        pushed++;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int n = 0; n < budget && sb_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  logic [15:0] dir_data [7] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                16'h0008, 16'h0010, 16'h0005};
  logic [30:0] dir_cw   [7] = '{31'h0000_8FAF, 31'h0001_1F5E, 31'h0001_90F1,
                                31'h0002_3EBC, 31'h0004_7D78, 31'h0008_755F,
                                31'h0002_B113};

  initial begin
    logic [30:0] saved;
    logic [15:0] rd;
    int          lat;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    data_in  = 16'h0000;
`ifdef BCH31163_ERR_INJECT_EN
    err_mask = 31'd0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_codeword", 32'(codeword_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_release", 32'(in_ready), 32'd1);

    // All-zero word, latency and re-arm timing
    ready_mode = 1;
    send_word(16'h0000, 31'd0, 31'h0000_0000, 1'b1, 0);
    @(negedge clk);
    check("shift_busy", 32'(busy), 32'd1);
    check("shift_in_ready", 32'(in_ready), 32'd0);
    lat = -1;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      if (out_valid) lat = cycle_cnt - acc_cycle;
      else @(negedge clk);
    end
    check("out_valid_latency", 32'(lat), 32'd16);
    lat = -1;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      if (in_ready) lat = cycle_cnt - acc_cycle;
      else @(negedge clk);
    end
    check("in_ready_latency", 32'(lat), 32'd18);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Directed vectors, back to back
    for (int i = 0; i < 7; i++) send_word(dir_data[i], 31'd0, dir_cw[i], 1'b1, 0);
    wait_drain(100);

    // Backpressure: 50 stalled cycles with in_valid high and data toggling
    ready_mode = 0;
    @(posedge clk);
    #1;
    send_word(16'h0003, 31'd0, 31'h0001_90F1, 1'b1, 0);
    for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
    saved = codeword_out;
    check("stall_codeword_value", 32'(saved), 32'h0001_90F1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      data_in  = (i % 2 == 0) ? 16'hFFFF : 16'h1234;
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_codeword", 32'(codeword_out), 32'(saved));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    ready_mode = 1;
    wait_drain(20);
    repeat (20) @(posedge clk);
    #1;
    check("no_extra_accept_valid", 32'(out_valid), 32'd0);
    check("no_extra_accept_busy", 32'(busy), 32'd0);

    // Reset in the middle of shifting 16'hA5A5
    send_word(16'hA5A5, 31'd0, 31'd0, 1'b0, 0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_codeword", 32'(codeword_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(16'h0001, 31'd0, 31'h0000_8FAF, 1'b1, 0);
    wait_drain(60);

`ifdef BCH31163_ERR_INJECT_EN
    // Error injection
    send_word(16'h0001, 31'h4000_0001, 31'h4000_8FAE, 1'b1, 0);
    send_word(16'h0001, 31'h0000_0000, 31'h0000_8FAF, 1'b1, 0);
    wait_drain(60);
`endif

    // Random words with random input gaps and output backpressure
    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      rd = 16'($urandom);
      send_word(rd, 31'd0, {rd, poly_mod({rd, 15'd0})}, 1'b1, $urandom_range(0, 3));
    end
    wait_drain(800);
    ready_mode = 1;

    check("pushed_equals_popped", 32'(popped), 32'(pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
